pipeline_hazard_ctrl: RTL

Parametrised hazard and stall controller for the 5-stage RISC-V pipeline core. It drives the core's enable and active-low clear inputs for the IF/ID, ID/EX and EX/MEM pipeline registers, plus new PC and MEM/WB enables. It also drives EX-stage operand forwarding selects. It adds load-use stalls, branch/JAL flush, configurable RAM wait states and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: pipeline-register enables and clears,
// EX operand forwarding selects, RAM wait-state freeze and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MEM_WAIT   = 0,
   parameter bit FWD_EN     = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic                  CLOCK,
   input  logic                  RST_n,
   input  logic [REG_ADDR_W-1:0] rs1_ID,
   input  logic [REG_ADDR_W-1:0] rs2_ID,
   input  logic                  use_rs1_ID,
   input  logic                  use_rs2_ID,
   input  logic [REG_ADDR_W-1:0] rs1_EX,
   input  logic [REG_ADDR_W-1:0] rs2_EX,
   input  logic [REG_ADDR_W-1:0] rd_EX,
   input  logic                  RegWrite_EX,
   input  logic                  MemRead_EX,
   input  logic [REG_ADDR_W-1:0] rd_MEM,
   input  logic                  RegWrite_MEM,
   input  logic                  mem_req_MEM,
   input  logic [REG_ADDR_W-1:0] rd_WB,
   input  logic                  RegWrite_WB,
   input  logic                  PCSrc_EX,
   output logic                  EN_PC,
   output logic                  EN_IFID,
   output logic                  EN_IDEX,
   output logic                  EN_EXMEM,
   output logic                  EN_MEMWB,
   output logic                  clear_IFID,
   output logic                  clear_IDEX,
   output logic                  clear_EXMEM,
   output logic [1:0]            forwardA_EX,
   output logic [1:0]            forwardB_EX,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MEMWAIT = 1'b1;

   localparam bit         WAIT_ON   = (MEM_WAIT > 0);
   localparam logic [3:0] WAIT_LOAD = WAIT_ON ? 4'(MEM_WAIT - 1) : 4'd0;

   logic [0:0] state, state_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;

   logic hit_ex, hit_mem, hit_wb, load_use, raw;
   logic trigger, freeze, flush, stall;

   function automatic logic wr_hit(input logic we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
      return we && (rd != '0) && (rd == rs);
   endfunction

   always_comb begin
      hit_ex  = (use_rs1_ID && wr_hit(RegWrite_EX,  rd_EX,  rs1_ID)) ||
                (use_rs2_ID && wr_hit(RegWrite_EX,  rd_EX,  rs2_ID));
      hit_mem = (use_rs1_ID && wr_hit(RegWrite_MEM, rd_MEM, rs1_ID)) ||
                (use_rs2_ID && wr_hit(RegWrite_MEM, rd_MEM, rs2_ID));
      hit_wb  = (use_rs1_ID && wr_hit(RegWrite_WB,  rd_WB,  rs1_ID)) ||
                (use_rs2_ID && wr_hit(RegWrite_WB,  rd_WB,  rs2_ID));
      load_use = MemRead_EX && hit_ex;
      // The register file has no write-through, so a WB match stalls even with forwarding.
      raw = load_use || hit_wb || (!FWD_EN && (hit_ex || hit_mem));

      // Only RUN can start a wait; the release cycle never retriggers on the same access.
      trigger = (state == RUN) && mem_req_MEM && WAIT_ON;
      freeze  = trigger || ((state == MEMWAIT) && (wait_cnt != '0));
      flush   = PCSrc_EX && !freeze;
      stall   = raw && !freeze && !flush;
   end

   always_comb begin
      EN_PC       = 1'b1;
      EN_IFID     = 1'b1;
      EN_IDEX     = 1'b1;
      EN_EXMEM    = 1'b1;
      EN_MEMWB    = 1'b1;
      clear_IFID  = 1'b1;
      clear_IDEX  = 1'b1;
      clear_EXMEM = 1'b1;
      if (freeze) begin
         EN_PC    = 1'b0;
         EN_IFID  = 1'b0;
         EN_IDEX  = 1'b0;
         EN_EXMEM = 1'b0;
         EN_MEMWB = 1'b0;
      end else if (flush) begin
         clear_IFID = 1'b0;
         clear_IDEX = 1'b0;
      end else if (stall) begin
         EN_PC      = 1'b0;
         EN_IFID    = 1'b0;
         clear_IDEX = 1'b0;
      end
   end

   always_comb begin
      forwardA_EX = 2'b00;
      forwardB_EX = 2'b00;
      if (FWD_EN) begin
         if (wr_hit(RegWrite_MEM, rd_MEM, rs1_EX))     forwardA_EX = 2'b10;
         else if (wr_hit(RegWrite_WB, rd_WB, rs1_EX))  forwardA_EX = 2'b01;
         if (wr_hit(RegWrite_MEM, rd_MEM, rs2_EX))     forwardB_EX = 2'b10;
         else if (wr_hit(RegWrite_WB, rd_WB, rs2_EX))  forwardB_EX = 2'b01;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      if (trigger) begin
         state_nxt    = MEMWAIT;
         wait_cnt_nxt = WAIT_LOAD;
      end else if (state == MEMWAIT) begin
         if (wait_cnt != '0) wait_cnt_nxt = wait_cnt - 4'd1;
         else                state_nxt    = RUN;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RST_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if ((freeze || stall) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1))             flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
